// File: rtl/tmr_scrub_ctrl.sv
// tmr_scrub_ctrl: triple-modular-redundant configuration register with a
// periodic scrubber. Three copies are voted bitwise 2-of-3 into a registered
// output; every SCRUB_PERIOD idle cycles the copies are checked against the
// vote and any disagreeing copy is rewritten. Per-copy error counters, a
// repeated-failure (stuck) flag and a multi-copy-error flag are maintained.
module tmr_scrub_ctrl #(
  parameter int REG_WIDTH    = 8,
  parameter int SCRUB_PERIOD = 16,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [REG_WIDTH-1:0] wr_data,
  input  logic                 inj_en,
  input  logic [1:0]           inj_sel,
  input  logic [REG_WIDTH-1:0] inj_mask,
  input  logic                 clr_err,
  output logic [REG_WIDTH-1:0] q,
  output logic                 mismatch,
  output logic [CNT_WIDTH-1:0] err_cnt0,
  output logic [CNT_WIDTH-1:0] err_cnt1,
  output logic [CNT_WIDTH-1:0] err_cnt2,
  output logic [2:0]           stuck,
  output logic                 multi_err
);

  localparam int TW = (SCRUB_PERIOD > 2) ? $clog2(SCRUB_PERIOD) : 1;
  localparam logic [TW-1:0]        TIMER_LAST = TW'(SCRUB_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_REPAIR = 2'd2
  } state_t;

  state_t               state_r;
  logic [TW-1:0]        timer_r;
  logic [REG_WIDTH-1:0] copy_r [3];
  logic [REG_WIDTH-1:0] vote_r;
  logic [2:0]           bad_r;
  logic [2:0]           hist_r;
  logic [CNT_WIDTH-1:0] cnt_r [3];
  logic [REG_WIDTH-1:0] q_r;
  logic                 mismatch_r;
  logic [2:0]           stuck_r;
  logic                 multi_err_r;

  logic [REG_WIDTH-1:0] vote_s;
  logic [2:0]           bad_s;

  // Number of set bits in a 3-bit bad-copy mask.
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

  // Bitwise 2-of-3 vote and per-copy disagreement against it.
  always_comb begin
    vote_s = (copy_r[0] & copy_r[1]) | (copy_r[0] & copy_r[2]) | (copy_r[1] & copy_r[2]);
    bad_s  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      bad_s[i] = (copy_r[i] != vote_s);
    end
  end

  // Copy storage: host write beats scrub repair, which beats fault injection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        copy_r[i] <= {REG_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (wr_en) begin
          copy_r[i] <= wr_data;
        end else if ((state_r == ST_REPAIR) && bad_r[i]) begin
          copy_r[i] <= vote_r;
        end else if (inj_en && (inj_sel == 2'(i))) begin
          copy_r[i] <= copy_r[i] ^ inj_mask;
        end else begin
          copy_r[i] <= copy_r[i];
        end
      end
    end
  end

  // Scrub FSM, registered vote output and error statistics; clr_err wins last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      timer_r     <= {TW{1'b0}};
      vote_r      <= {REG_WIDTH{1'b0}};
      bad_r       <= 3'b000;
      hist_r      <= 3'b000;
      q_r         <= {REG_WIDTH{1'b0}};
      mismatch_r  <= 1'b0;
      stuck_r     <= 3'b000;
      multi_err_r <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      q_r        <= vote_s;
      mismatch_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (wr_en) begin
            timer_r <= {TW{1'b0}};
          end else if (timer_r == TIMER_LAST) begin
            timer_r <= {TW{1'b0}};
            state_r <= ST_CHECK;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_CHECK: begin
          timer_r <= {TW{1'b0}};
          if (wr_en) begin
            // A fresh write supersedes whatever this check would have found.
            state_r <= ST_IDLE;
          end else if (bad_s == 3'b000) begin
            state_r <= ST_IDLE;
            hist_r  <= 3'b000;
          end else begin
            bad_r      <= bad_s;
            vote_r     <= vote_s;
            mismatch_r <= 1'b1;
            state_r    <= ST_REPAIR;
          end
        end
        ST_REPAIR: begin
          timer_r <= {TW{1'b0}};
          state_r <= ST_IDLE;
          for (int i = 0; i < 3; i++) begin
            if (bad_r[i] && (cnt_r[i] != CNT_MAX)) begin
              cnt_r[i] <= cnt_r[i] + CNT_WIDTH'(1);
            end else begin
              cnt_r[i] <= cnt_r[i];
            end
          end
          if (popcount3(bad_r) >= 2'd2) begin
            multi_err_r <= 1'b1;
          end else begin
            multi_err_r <= multi_err_r;
          end
          stuck_r <= stuck_r | (bad_r & hist_r);
          hist_r  <= bad_r;
        end
        default: begin
          state_r <= ST_IDLE;
          timer_r <= {TW{1'b0}};
        end
      endcase
      if (clr_err) begin
        for (int i = 0; i < 3; i++) begin
          cnt_r[i] <= {CNT_WIDTH{1'b0}};
        end
        stuck_r     <= 3'b000;
        multi_err_r <= 1'b0;
        hist_r      <= 3'b000;
      end
    end
  end

  assign q         = q_r;
  assign mismatch  = mismatch_r;
  assign err_cnt0  = cnt_r[0];
  assign err_cnt1  = cnt_r[1];
  assign err_cnt2  = cnt_r[2];
  assign stuck     = stuck_r;
  assign multi_err = multi_err_r;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed testbench for tmr_scrub_ctrl with hand-computed expectations.
module tb_tmr_scrub_ctrl;
  localparam int RW = 8;
  localparam int P  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [RW-1:0] wr_data = 8'h00;
  logic          inj_en = 1'b0;
  logic [1:0]    inj_sel = 2'd0;
  logic [RW-1:0] inj_mask = 8'h00;
  logic          clr_err = 1'b0;
  logic [RW-1:0] q;
  logic          mismatch;
  logic [CW-1:0] err_cnt0, err_cnt1, err_cnt2;
  logic [2:0]    stuck;
  logic          multi_err;

  int compared = 0;
  int mismatched = 0;

  tmr_scrub_ctrl #(.REG_WIDTH(RW), .SCRUB_PERIOD(P), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask), .clr_err(clr_err),
    .q(q), .mismatch(mismatch), .err_cnt0(err_cnt0), .err_cnt1(err_cnt1),
    .err_cnt2(err_cnt2), .stuck(stuck), .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic write(input logic [RW-1:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic inject(input logic [1:0] sel, input logic [RW-1:0] m);
    inj_en = 1'b1; inj_sel = sel; inj_mask = m;
    tick();
    inj_en = 1'b0; inj_mask = 8'h00;
  endtask

  task automatic clear();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    // Reset state
    ticks(2);
    check("rst_q", 32'(q), 32'h0);
    check("rst_mismatch", 32'(mismatch), 32'h0);
    check("rst_cnt0", 32'(err_cnt0), 32'h0);
    check("rst_cnt2", 32'(err_cnt2), 32'h0);
    check("rst_stuck", 32'(stuck), 32'h0);
    check("rst_multi", 32'(multi_err), 32'h0);
    check("rst_c1", 32'(dut.copy_r[1]), 32'h0);
    rst_n = 1'b1;
    tick();

    // Write then quiet period
    write(8'hA5);
    check("wr_c0", 32'(dut.copy_r[0]), 32'hA5);
    check("wr_c1", 32'(dut.copy_r[1]), 32'hA5);
    check("wr_c2", 32'(dut.copy_r[2]), 32'hA5);
    check("wr_q_lag", 32'(q), 32'h0);
    tick();
    check("wr_q", 32'(q), 32'hA5);
    for (int k = 0; k < 100; k++) begin
      tick();
      check("quiet_mismatch", 32'(mismatch), 32'h0);
    end
    check("quiet_cnt0", 32'(err_cnt0), 32'h0);
    check("quiet_cnt1", 32'(err_cnt1), 32'h0);
    check("quiet_cnt2", 32'(err_cnt2), 32'h0);

    // Single injection into copy 1
    write(8'hA5);
    inject(2'd1, 8'h0F);
    check("inj_c1", 32'(dut.copy_r[1]), 32'hAA);
    check("inj_q", 32'(q), 32'hA5);
    ticks(P - 1);
    check("inj_check_nomis", 32'(mismatch), 32'h0);
    check("inj_q2", 32'(q), 32'hA5);
    tick();
    check("inj_repair_mis", 32'(mismatch), 32'h1);
    check("inj_cnt1_pre", 32'(err_cnt1), 32'h0);
    tick();
    check("inj_mis_low", 32'(mismatch), 32'h0);
    check("inj_cnt1", 32'(err_cnt1), 32'h1);
    check("inj_cnt0", 32'(err_cnt0), 32'h0);
    check("inj_cnt2", 32'(err_cnt2), 32'h0);
    check("inj_c1_fixed", 32'(dut.copy_r[1]), 32'hA5);
    check("inj_multi", 32'(multi_err), 32'h0);
    check("inj_stuck", 32'(stuck), 32'h0);

    // Stuck: copy 2 bad in two back-to-back repairing passes
    clear();
    write(8'hA5);
    inject(2'd2, 8'h01);
    ticks(P + 1);
    check("stk_cnt2_a", 32'(err_cnt2), 32'h1);
    check("stk_stuck_a", 32'(stuck), 32'h0);
    inject(2'd2, 8'h01);
    ticks(P - 1);
    tick();
    check("stk_mis", 32'(mismatch), 32'h1);
    check("stk_stuck_pre", 32'(stuck), 32'h0);
    tick();
    check("stk_stuck", 32'(stuck), 32'h4);
    check("stk_cnt2", 32'(err_cnt2), 32'h2);
    check("stk_c2", 32'(dut.copy_r[2]), 32'hA5);

    // Stuck not set when a clean check separates the passes
    clear();
    check("clr_stuck", 32'(stuck), 32'h0);
    check("clr_cnt2", 32'(err_cnt2), 32'h0);
    write(8'hA5);
    inject(2'd2, 8'h01);
    ticks(P + 1);
    ticks(P);
    check("gap_clean_nomis", 32'(mismatch), 32'h0);
    inject(2'd2, 8'h01);
    ticks(P);
    tick();
    check("gap_mis", 32'(mismatch), 32'h1);
    tick();
    check("gap_stuck", 32'(stuck), 32'h0);
    check("gap_cnt2", 32'(err_cnt2), 32'h2);

    // Multi error: copies 0 and 1 disturbed
    clear();
    write(8'hA5);
    inject(2'd0, 8'h01);
    inject(2'd1, 8'h02);
    check("mul_q", 32'(q), 32'hA5);
    ticks(P - 2);
    tick();
    check("mul_mis", 32'(mismatch), 32'h1);
    tick();
    check("mul_multi", 32'(multi_err), 32'h1);
    check("mul_cnt0", 32'(err_cnt0), 32'h1);
    check("mul_cnt1", 32'(err_cnt1), 32'h1);
    check("mul_cnt2", 32'(err_cnt2), 32'h0);
    check("mul_c0", 32'(dut.copy_r[0]), 32'hA5);
    check("mul_c1", 32'(dut.copy_r[1]), 32'hA5);
    check("mul_q2", 32'(q), 32'hA5);

    // Abort: write during the CHECK cycle of a pending mismatch
    clear();
    check("clr_multi", 32'(multi_err), 32'h0);
    write(8'hA5);
    inject(2'd1, 8'h0F);
    ticks(P - 1);
    write(8'h3C);
    check("abt_nomis", 32'(mismatch), 32'h0);
    check("abt_c0", 32'(dut.copy_r[0]), 32'h3C);
    check("abt_c1", 32'(dut.copy_r[1]), 32'h3C);
    check("abt_c2", 32'(dut.copy_r[2]), 32'h3C);
    check("abt_cnt1", 32'(err_cnt1), 32'h0);
    inject(2'd0, 8'h10);
    check("abt_q", 32'(q), 32'h3C);
    tick();
    check("abt_nomis2", 32'(mismatch), 32'h0);
    ticks(P - 2);
    check("abt_check_nomis", 32'(mismatch), 32'h0);
    tick();
    check("abt_cadence_mis", 32'(mismatch), 32'h1);
    tick();
    check("abt_cnt0", 32'(err_cnt0), 32'h1);
    check("abt_cnt1b", 32'(err_cnt1), 32'h0);
    check("abt_c0_fixed", 32'(dut.copy_r[0]), 32'h3C);

    // Saturation of a 2-bit counter, then clear
    clear();
    write(8'hA5);
    for (int k = 0; k < 4; k++) begin
      inject(2'd0, 8'h01);
      ticks(P + 1);
      check("sat_cnt0", 32'(err_cnt0), (k < 3) ? 32'(k + 1) : 32'h3);
    end
    check("sat_stuck", 32'(stuck), 32'h1);
    clear();
    check("sat_clr_cnt0", 32'(err_cnt0), 32'h0);
    check("sat_clr_stuck", 32'(stuck), 32'h0);
    check("sat_clr_multi", 32'(multi_err), 32'h0);

    // clr_err in the REPAIR cycle drops that pass's increment
    write(8'hA5);
    inject(2'd0, 8'h01);
    ticks(P - 1);
    tick();
    check("crp_mis", 32'(mismatch), 32'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("crp_cnt0", 32'(err_cnt0), 32'h0);
    check("crp_c0", 32'(dut.copy_r[0]), 32'hA5);

    // Asynchronous reset in the middle of a repair
    write(8'h5A);
    inject(2'd2, 8'h01);
    ticks(P - 1);
    tick();
    check("ars_mis_pre", 32'(mismatch), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("ars_mis", 32'(mismatch), 32'h0);
    check("ars_q", 32'(q), 32'h0);
    check("ars_c2", 32'(dut.copy_r[2]), 32'h0);
    check("ars_c0", 32'(dut.copy_r[0]), 32'h0);
    tick();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
